// File: rtl/lcd_byte_writer_pkg.sv
// ---------------------------------------------------------------------------
// lcd_byte_writer_pkg
// Shared definitions for the HD44780 byte writer: FSM state encoding,
// well-known command bytes and small helpers used by the top level.
//
// Build option: define LCD_INIT_EN to compile in the automatic 4-bit
// power-up sequence (extra init states, init nibble table, post-waits).
// ---------------------------------------------------------------------------
package lcd_byte_writer_pkg;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

`ifdef LCD_INIT_EN
    // Post-nibble execution waits of the power-up sequence, in clocks.
    localparam int INIT_POST_0 = 205000;
    localparam int INIT_POST_1 = 5000;
    localparam int INIT_POST_2 = 2000;
    localparam int INIT_POST_3 = 2000;

    typedef enum logic [3:0] {
        LCD_IDLE,
        LCD_SETUP_HI,
        LCD_PULSE_HI,
        LCD_GAP,
        LCD_SETUP_LO,
        LCD_PULSE_LO,
        LCD_WAIT,
        LCD_INIT_PWR,
        LCD_INIT_WAIT,
        LCD_INIT_SETUP,
        LCD_INIT_PULSE,
        LCD_INIT_NIB
    } lcd_state_e;

    // Nibbles 0..2 are the 8-bit "function set" wake-ups, nibble 3 selects
    // 4-bit mode.
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic int init_post(input logic [1:0] idx);
        case (idx)
            2'd0:    return INIT_POST_0;
            2'd1:    return INIT_POST_1;
            2'd2:    return INIT_POST_2;
            default: return INIT_POST_3;
        endcase
    endfunction
`else
    typedef enum logic [2:0] {
        LCD_IDLE,
        LCD_SETUP_HI,
        LCD_PULSE_HI,
        LCD_GAP,
        LCD_SETUP_LO,
        LCD_PULSE_LO,
        LCD_WAIT
    } lcd_state_e;
`endif

    // Clear (0x01) and return-home (0x02/0x03) are the slow commands; the
    // controller needs the long execution wait after them.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_byte_writer_delay.sv
// ---------------------------------------------------------------------------
// lcd_delay_timer
// Loadable down-counter shared by every timed state of the LCD writer.
// Loading N-1 on state entry makes a state last exactly N clocks, since the
// FSM leaves the state on the edge where the counter already reads 0.
//
// Ports:
//   Clock     system clock
//   Reset     asynchronous active-low reset (counter clears to 0)
//   load      load load_val this cycle (wins over counting)
//   load_val  value to load
//   done      counter is at 0
// ---------------------------------------------------------------------------
module lcd_delay_timer #(
    parameter int CNT_W = 20
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating down-count; a load always takes priority so the FSM can
    // retrigger on the same edge it sees done.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// ---------------------------------------------------------------------------
// lcd_byte_writer
// Accepts command/data bytes over a valid/ready handshake and writes them to
// an HD44780 LCD in 4-bit mode: high nibble then low nibble, each with its
// own E strobe, with all setup, pulse and execution delays enforced so the
// CPU can issue one write per byte without polling.
//
// Build option: LCD_INIT_EN runs the 4-bit power-up sequence after reset
// (oReady held low until it completes). Undefined: software initialises.
//
// Ports:
//   Clock     system clock
//   Reset     asynchronous active-low reset
//   iData     byte to write
//   iRS       0 = command, 1 = display data
//   iValid    iData/iRS valid this cycle
//   oReady    idle, a byte is accepted on iValid at the next rising edge
//   oLCD_E    LCD enable strobe
//   oLCD_RS   LCD register select
//   oLCD_RW   LCD read/write, always 0 (write only)
//   oLCD_D    LCD data bus D[7:4]
// ---------------------------------------------------------------------------
module lcd_byte_writer
    import lcd_byte_writer_pkg::*;
#(
    parameter int SETUP_CYC      = 2,
    parameter int PULSE_CYC      = 12,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int BYTE_WAIT_CYC  = 2000,
    parameter int LONG_WAIT_CYC  = 82000,
    parameter int POWERUP_CYC    = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_D
);

    lcd_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             ready_q, ready_d;
    logic             e_q, e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [3:0]       lcd_d_q, lcd_d_d;
`ifdef LCD_INIT_EN
    logic [1:0]       nib_q, nib_d;
`endif

    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;

    function automatic logic [CNT_W-1:0] cyc_m1(input int n);
        return CNT_W'(n - 1);
    endfunction

    lcd_delay_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // Next-state logic. Every transition reloads the timer with the length
    // of the state being entered, so each state simply waits for done.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rs_d       = rs_q;
        timer_load = 1'b0;
        timer_val  = '0;
`ifdef LCD_INIT_EN
        nib_d      = nib_q;
`endif
        case (state_q)
            LCD_IDLE: begin
                if (iValid && ready_q) begin
                    data_d     = iData;
                    rs_d       = iRS;
                    state_d    = LCD_SETUP_HI;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(SETUP_CYC);
                end
            end
            LCD_SETUP_HI: begin
                if (timer_done) begin
                    state_d    = LCD_PULSE_HI;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(PULSE_CYC);
                end
            end
            LCD_PULSE_HI: begin
                if (timer_done) begin
                    state_d    = LCD_GAP;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(NIBBLE_GAP_CYC);
                end
            end
            LCD_GAP: begin
                if (timer_done) begin
                    state_d    = LCD_SETUP_LO;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(SETUP_CYC);
                end
            end
            LCD_SETUP_LO: begin
                if (timer_done) begin
                    state_d    = LCD_PULSE_LO;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(PULSE_CYC);
                end
            end
            LCD_PULSE_LO: begin
                if (timer_done) begin
                    state_d    = LCD_WAIT;
                    timer_load = 1'b1;
                    timer_val  = is_long_cmd(rs_q, data_q) ? cyc_m1(LONG_WAIT_CYC)
                                                           : cyc_m1(BYTE_WAIT_CYC);
                end
            end
            LCD_WAIT: begin
                if (timer_done) begin
                    state_d = LCD_IDLE;
                end
            end
`ifdef LCD_INIT_EN
            // The reset state costs one clock, so it loads POWERUP_CYC-2 to
            // keep the total power-on wait at POWERUP_CYC clocks.
            LCD_INIT_PWR: begin
                state_d    = LCD_INIT_WAIT;
                timer_load = 1'b1;
                timer_val  = CNT_W'(POWERUP_CYC - 2);
            end
            LCD_INIT_WAIT: begin
                if (timer_done) begin
                    state_d    = LCD_INIT_SETUP;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(SETUP_CYC);
                end
            end
            LCD_INIT_SETUP: begin
                if (timer_done) begin
                    state_d    = LCD_INIT_PULSE;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(PULSE_CYC);
                end
            end
            LCD_INIT_PULSE: begin
                if (timer_done) begin
                    state_d    = LCD_INIT_NIB;
                    timer_load = 1'b1;
                    timer_val  = cyc_m1(init_post(nib_q));
                end
            end
            LCD_INIT_NIB: begin
                if (timer_done) begin
                    if (nib_q == 2'd3) begin
                        state_d = LCD_IDLE;
                    end else begin
                        nib_d      = nib_q + 2'd1;
                        state_d    = LCD_INIT_SETUP;
                        timer_load = 1'b1;
                        timer_val  = cyc_m1(SETUP_CYC);
                    end
                end
            end
`endif
            default: begin
                state_d = LCD_IDLE;
            end
        endcase
    end

    // Bus outputs are registered from the next state so they change on the
    // same edge as the state and drop straight to 0 under async reset.
    always_comb begin
        ready_d  = (state_d == LCD_IDLE);
        e_d      = 1'b0;
        lcd_rs_d = 1'b0;
        lcd_d_d  = 4'h0;
        case (state_d)
            LCD_SETUP_HI, LCD_GAP: begin
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[7:4];
            end
            LCD_PULSE_HI: begin
                e_d      = 1'b1;
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[7:4];
            end
            LCD_SETUP_LO, LCD_WAIT: begin
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[3:0];
            end
            LCD_PULSE_LO: begin
                e_d      = 1'b1;
                lcd_rs_d = rs_d;
                lcd_d_d  = data_d[3:0];
            end
`ifdef LCD_INIT_EN
            LCD_INIT_SETUP, LCD_INIT_NIB: begin
                lcd_d_d = init_nibble(nib_d);
            end
            LCD_INIT_PULSE: begin
                e_d     = 1'b1;
                lcd_d_d = init_nibble(nib_d);
            end
`endif
            default: begin
            end
        endcase
    end

    // State, holding and output registers. oReady resets low so the first
    // edge after reset release is what raises it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
`ifdef LCD_INIT_EN
            state_q  <= LCD_INIT_PWR;
            nib_q    <= 2'd0;
`else
            state_q  <= LCD_IDLE;
`endif
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            ready_q  <= 1'b0;
            e_q      <= 1'b0;
            lcd_rs_q <= 1'b0;
            lcd_d_q  <= 4'h0;
        end else begin
            state_q  <= state_d;
`ifdef LCD_INIT_EN
            nib_q    <= nib_d;
`endif
            data_q   <= data_d;
            rs_q     <= rs_d;
            ready_q  <= ready_d;
            e_q      <= e_d;
            lcd_rs_q <= lcd_rs_d;
            lcd_d_q  <= lcd_d_d;
        end
    end

    assign oReady  = ready_q;
    assign oLCD_E  = e_q;
    assign oLCD_RS = lcd_rs_q;
    assign oLCD_RW = 1'b0;
    assign oLCD_D  = lcd_d_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_byte_writer
// Directed and randomized writes to lcd_byte_writer. Expected bus activity
// for each byte is derived from the timing rules as a per-cycle profile
// (nibble windows, strobe windows, busy length) and compared every cycle.
// Delay parameters are shortened so the whole run stays small.
// ---------------------------------------------------------------------------
module tb_lcd_byte_writer;

    localparam int S  = 2;
    localparam int P  = 12;
    localparam int G  = 50;
    localparam int BW = 150;
    localparam int LW = 600;
    localparam int TIMEOUT = 4 * LW;

    logic       clock;
    logic       rstN;
    logic [7:0] iData;
    logic       iRS;
    logic       iValid;
    logic       oReady;
    logic       oLCD_E;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic [3:0] oLCD_D;
    logic [7:0] outs;

    int vecCount  = 0;
    int missCount = 0;

    lcd_byte_writer #(
        .SETUP_CYC      (S),
        .PULSE_CYC      (P),
        .NIBBLE_GAP_CYC (G),
        .BYTE_WAIT_CYC  (BW),
        .LONG_WAIT_CYC  (LW),
        .POWERUP_CYC    (1000),
        .CNT_W          (20)
    ) dut (
        .Clock   (clock),
        .Reset   (rstN),
        .iData   (iData),
        .iRS     (iRS),
        .iValid  (iValid),
        .oReady  (oReady),
        .oLCD_E  (oLCD_E),
        .oLCD_RS (oLCD_RS),
        .oLCD_RW (oLCD_RW),
        .oLCD_D  (oLCD_D)
    );

    assign outs = {oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_D};

    always #5 clock = ~clock;

    // Busy length in clocks: both nibbles plus the execution wait, which is
    // long only for commands 0x00..0x03.
    function automatic int busyLen(input logic [7:0] data, input logic rs);
        int waitLen;
        waitLen = (rs == 1'b0 && data < 8'h04) ? LW : BW;
        return 2 * S + 2 * P + G + waitLen;
    endfunction

    // Expected {ready,E,RS,RW,D} k edges after acceptance, counting the
    // accept edge as edge 1.
    function automatic logic [7:0] expectVec(input int k, input logic [7:0] data,
                                             input logic rs, input int total);
        logic       ready;
        logic       e;
        logic       rsOut;
        logic [3:0] d;
        int         hiEnd;
        hiEnd = S + P + G;
        ready = (k > total);
        e     = (k > S && k <= S + P) || (k > hiEnd + S && k <= hiEnd + S + P);
        rsOut = (k <= total) ? rs : 1'b0;
        if (k <= hiEnd)      d = data[7:4];
        else if (k <= total) d = data[3:0];
        else                 d = 4'h0;
        return {ready, e, rsOut, 1'b0, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vecCount++;
        assert (observed === expected) else begin
            missCount++;
            $error("[TB] FAIL %s observed=%b expected=%b (ready,E,RS,RW,D)",
                   tag, observed, expected);
        end
    endtask

    task automatic waitReady();
        int guard;
        guard = 0;
        while (oReady !== 1'b1 && guard < TIMEOUT) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("ready_wait", {7'd0, oReady}, 8'd1);
    endtask

    // Write one byte and check every cycle until the block is idle again.
    // holdBusy keeps iValid high with junk bytes while the block is busy.
    task automatic applyStimulus(input logic [7:0] data, input logic rs, input bit holdBusy);
        int total;
        total = busyLen(data, rs);
        waitReady();
        iData  = data;
        iRS    = rs;
        iValid = 1'b1;
        @(negedge clock);
        for (int k = 1; k <= total + 1; k++) begin
            checkOutput($sformatf("byte_%h_rs%0d_k%0d", data, rs, k), outs,
                        expectVec(k, data, rs, total));
            if (holdBusy && k <= total) begin
                iData  = 8'($urandom);
                iRS    = 1'($urandom);
                iValid = 1'b1;
            end else begin
                iValid = 1'b0;
            end
            if (k <= total) @(negedge clock);
        end
    endtask

    // Start a byte, pull reset in the middle of the first E pulse and check
    // that everything drops immediately and recovers cleanly.
    task automatic abortDuringPulse(input logic [7:0] data, input logic rs);
        waitReady();
        iData  = data;
        iRS    = rs;
        iValid = 1'b1;
        @(negedge clock);
        iValid = 1'b0;
        repeat (S + 1) @(negedge clock);
        checkOutput("abort_in_pulse", outs, expectVec(S + 2, data, rs, busyLen(data, rs)));
        #2 rstN = 1'b0;
        #1 checkOutput("abort_e_drop", outs, 8'h00);
        @(negedge clock);
        checkOutput("abort_hold", outs, 8'h00);
        rstN = 1'b1;
        #1 checkOutput("abort_release_pre_edge", outs, 8'h00);
        @(negedge clock);
        checkOutput("abort_recover_idle", outs, 8'h80);
    endtask

    initial begin
        logic [7:0] d;
        logic       r;
        clock  = 1'b0;
        rstN   = 1'b0;
        iData  = 8'h00;
        iRS    = 1'b0;
        iValid = 1'b0;

        #3 checkOutput("reset_outputs", outs, 8'h00);
        iValid = 1'b1;
        iData  = 8'hFF;
        repeat (2) @(negedge clock);
        checkOutput("reset_hold_valid", outs, 8'h00);
        iValid = 1'b0;
        rstN   = 1'b1;
        #1 checkOutput("release_pre_edge", outs, 8'h00);
        @(negedge clock);
        checkOutput("ready_first_edge", outs, 8'h80);

        $display("[TB] directed writes");
        applyStimulus(8'h41, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0);
        applyStimulus(8'h48, 1'b1, 1'b1);
        applyStimulus(8'h49, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b0, 1'b0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        applyStimulus(8'h04, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0);

        $display("[TB] reset abort");
        abortDuringPulse(8'h55, 1'b1);
        applyStimulus(8'h30, 1'b0, 1'b0);

        $display("[TB] randomized writes");
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            r = 1'($urandom);
            if ((i % 4) == 0) begin
                d = {6'd0, d[1:0]};
                r = 1'b0;
            end
            applyStimulus(d, r, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
